// File: rtl/fsm_event_counter.sv
// Counts qualified events on FSM_in and pulses FSM_out once COUNT_N have been seen.
// Optional inactivity abort while counting is compiled in with FSM_CNT_TIMEOUT_EN.

module fsm_event_counter #(
    parameter int CNT_W        = 4,
    parameter int COUNT_N      = 5,
    parameter int EDGE_MODE    = 0,
    parameter int AUTO_RESTART = 1,
    parameter int TIMEOUT_CYC  = 16
) (
    input  logic             Clk,
    input  logic             rst_n,
    input  logic             FSM_en,
    input  logic             FSM_clr,
    input  logic             FSM_in,
    output logic             FSM_out,
    output logic             FSM_busy,
    output logic             FSM_hold,
    output logic [CNT_W-1:0] FSM_cnt,
    output logic             FSM_timeout
);

    // state | meaning
    // IDLE  | no sequence in progress, cnt = 0
    // COUNT | sequence in progress, cnt = events accepted so far
    // HOLD  | sequence complete, parked until FSM_clr (AUTO_RESTART = 0)
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        COUNT = 3'b001,
        HOLD  = 3'b010
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_N - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             out_q;
    logic             out_nxt;
    logic             in_d;
    logic             ev;
    logic             tmo_hit;

    // in_d is always referenced so level mode does not leave it dangling
    assign ev = FSM_en & FSM_in & ((EDGE_MODE == 0) | ~in_d);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = 1'b0;
        if (FSM_clr) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (tmo_hit) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev) begin
                        state_nxt = COUNT;
                        cnt_nxt   = CNT_W'(1);
                    end else begin
                        cnt_nxt   = '0;
                    end
                end
                COUNT: begin
                    if (ev) begin
                        if (cnt == CNT_LAST) begin
                            cnt_nxt   = '0;
                            out_nxt   = 1'b1;
                            state_nxt = (AUTO_RESTART != 0) ? IDLE : HOLD;
                        end else begin
                            cnt_nxt   = cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            out_q <= 1'b0;
            in_d  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            out_q <= out_nxt;
            in_d  <= FSM_in;
        end
    end

`ifdef FSM_CNT_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] timer;
    logic             tmo_q;

    assign tmo_hit = (state == COUNT) && (timer == TMR_W'(TIMEOUT_CYC));

    // Timer only runs while the sequence stays in COUNT without a new event
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_hit & ~FSM_clr;
            if (FSM_clr || ev || tmo_hit || (state_nxt != COUNT))
                timer <= '0;
            else
                timer <= timer + TMR_W'(1);
        end
    end

    assign FSM_timeout = tmo_q;
`else
    assign tmo_hit     = 1'b0;
    assign FSM_timeout = 1'b0;
`endif

    assign FSM_out  = out_q;
    assign FSM_cnt  = cnt;
    assign FSM_busy = (state == COUNT);
    assign FSM_hold = (state == HOLD);

endmodule

// File: tb/tb_fsm_event_counter.sv
// Drives three configurations of fsm_event_counter (level, edge, hold-after-done)
// with directed and random stimulus and compares against an occurrence-count model.

module tb_fsm_event_counter;

    localparam int CNT_W       = 4;
    localparam int COUNT_N     = 5;
    localparam int TIMEOUT_CYC = 16;
    localparam int NI          = 3;

    logic Clk;
    logic rst_n;
    logic FSM_en;
    logic FSM_clr;
    logic FSM_in;

    logic             out_w  [NI];
    logic             busy_w [NI];
    logic             hold_w [NI];
    logic [CNT_W-1:0] cnt_w  [NI];
    logic             tmo_w  [NI];

    int vectors;
    int miscompares;

    // model state per instance: events so far, quiet cycles, parked flag
    int n_m     [NI];
    int quiet_m [NI];
    bit hold_m  [NI];
    bit prev_m  [NI];
    bit out_m   [NI];
    bit tmo_m   [NI];

    fsm_event_counter #(.CNT_W(CNT_W), .COUNT_N(COUNT_N), .EDGE_MODE(0), .AUTO_RESTART(1),
                        .TIMEOUT_CYC(TIMEOUT_CYC)) u_lvl (
        .Clk(Clk), .rst_n(rst_n), .FSM_en(FSM_en), .FSM_clr(FSM_clr), .FSM_in(FSM_in),
        .FSM_out(out_w[0]), .FSM_busy(busy_w[0]), .FSM_hold(hold_w[0]),
        .FSM_cnt(cnt_w[0]), .FSM_timeout(tmo_w[0]));

    fsm_event_counter #(.CNT_W(CNT_W), .COUNT_N(COUNT_N), .EDGE_MODE(1), .AUTO_RESTART(1),
                        .TIMEOUT_CYC(TIMEOUT_CYC)) u_edge (
        .Clk(Clk), .rst_n(rst_n), .FSM_en(FSM_en), .FSM_clr(FSM_clr), .FSM_in(FSM_in),
        .FSM_out(out_w[1]), .FSM_busy(busy_w[1]), .FSM_hold(hold_w[1]),
        .FSM_cnt(cnt_w[1]), .FSM_timeout(tmo_w[1]));

    fsm_event_counter #(.CNT_W(CNT_W), .COUNT_N(COUNT_N), .EDGE_MODE(0), .AUTO_RESTART(0),
                        .TIMEOUT_CYC(TIMEOUT_CYC)) u_hold (
        .Clk(Clk), .rst_n(rst_n), .FSM_en(FSM_en), .FSM_clr(FSM_clr), .FSM_in(FSM_in),
        .FSM_out(out_w[2]), .FSM_busy(busy_w[2]), .FSM_hold(hold_w[2]),
        .FSM_cnt(cnt_w[2]), .FSM_timeout(tmo_w[2]));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_edge(input int i);
        return i == 1;
    endfunction

    function automatic bit is_auto(input int i);
        return i != 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            n_m[i] = 0; quiet_m[i] = 0; hold_m[i] = 0;
            prev_m[i] = 0; out_m[i] = 0; tmo_m[i] = 0;
        end
    endtask

    task automatic model_step(input bit en, input bit clr, input bit in);
        bit ev;
        bit tmo_on;
`ifdef FSM_CNT_TIMEOUT_EN
        tmo_on = 1'b1;
`else
        tmo_on = 1'b0;
`endif
        for (int i = 0; i < NI; i++) begin
            ev = en && in && (!is_edge(i) || !prev_m[i]);
            prev_m[i] = in;
            out_m[i] = 0;
            tmo_m[i] = 0;
            if (clr) begin
                n_m[i] = 0; quiet_m[i] = 0; hold_m[i] = 0;
            end else if (tmo_on && n_m[i] > 0 && quiet_m[i] == TIMEOUT_CYC) begin
                n_m[i] = 0; quiet_m[i] = 0; tmo_m[i] = 1;
            end else if (hold_m[i]) begin
                n_m[i] = 0;
            end else if (ev) begin
                n_m[i]++;
                quiet_m[i] = 0;
                if (n_m[i] == COUNT_N) begin
                    n_m[i] = 0;
                    out_m[i] = 1;
                    if (!is_auto(i)) hold_m[i] = 1;
                end
            end else if (n_m[i] > 0) begin
                quiet_m[i]++;
            end
        end
    endtask

    task automatic compare_all(input string ph);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s/%0d out", ph, i),  32'(out_w[i]),  32'(out_m[i]));
            check($sformatf("%s/%0d busy", ph, i), 32'(busy_w[i]), 32'(n_m[i] > 0));
            check($sformatf("%s/%0d hold", ph, i), 32'(hold_w[i]), 32'(hold_m[i]));
            check($sformatf("%s/%0d cnt", ph, i),  32'(cnt_w[i]),  32'(n_m[i]));
            check($sformatf("%s/%0d tmo", ph, i),  32'(tmo_w[i]),  32'(tmo_m[i]));
        end
    endtask

    task automatic step(input string ph, input bit en, input bit clr, input bit in);
        @(negedge Clk);
        FSM_en = en; FSM_clr = clr; FSM_in = in;
        model_step(en, clr, in);
        @(posedge Clk);
        #1;
        compare_all(ph);
    endtask

    task automatic check_zero(input string ph);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s/%0d out", ph, i),  32'(out_w[i]),  32'd0);
            check($sformatf("%s/%0d busy", ph, i), 32'(busy_w[i]), 32'd0);
            check($sformatf("%s/%0d hold", ph, i), 32'(hold_w[i]), 32'd0);
            check($sformatf("%s/%0d cnt", ph, i),  32'(cnt_w[i]),  32'd0);
            check($sformatf("%s/%0d tmo", ph, i),  32'(tmo_w[i]),  32'd0);
        end
    endtask

    // reset asserted between clock edges must clear outputs without waiting for Clk
    task automatic async_reset(input string ph);
        @(negedge Clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(ph);
        model_reset();
        FSM_en = 1'b0; FSM_clr = 1'b0; FSM_in = 1'b0;
        @(negedge Clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        FSM_en = 1'b0; FSM_clr = 1'b0; FSM_in = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_zero("reset");
        @(negedge Clk);
        rst_n = 1'b1;

        // five level events then idle
        repeat (5) step("lvl5", 1, 0, 1);
        repeat (3) step("lvl5", 1, 0, 0);
        step("clr", 1, 1, 0);

        // long high then four single-cycle pulses
        repeat (10) step("edge", 1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            step("edge", 1, 0, 0);
            step("edge", 1, 0, 1);
        end
        step("edge", 1, 0, 0);
        step("clr", 1, 1, 0);

        // disabled gap in the middle of a sequence
        repeat (2) step("gap", 1, 0, 1);
        repeat (3) step("gap", 0, 0, 1);
        repeat (3) step("gap", 1, 0, 1);
        repeat (3) step("gap", 1, 0, 0);
        step("clr", 1, 1, 0);

        // ten events: second five land in HOLD for the non-restarting instance
        repeat (10) step("hold", 1, 0, 1);
        step("hold", 1, 0, 0);
        step("hold", 1, 1, 0);
        step("hold", 1, 0, 0);

        // clear coinciding with the final event
        for (int k = 0; k < 4; k++) begin
            step("clrev", 1, 0, 1);
            step("clrev", 1, 0, 0);
        end
        step("clrev", 1, 1, 1);
        step("clrev", 1, 0, 0);

        // async reset with three events accepted
        for (int k = 0; k < 3; k++) begin
            step("rst3", 1, 0, 1);
            step("rst3", 1, 0, 0);
        end
        async_reset("rst3");

`ifdef FSM_CNT_TIMEOUT_EN
        step("tmo", 1, 0, 1);
        step("tmo", 1, 0, 0);
        step("tmo", 1, 0, 1);
        repeat (20) step("tmo", 1, 0, 0);
        step("tmo", 1, 0, 1);
        step("tmo", 1, 0, 0);
        step("tmo", 1, 0, 1);
        repeat (14) step("tmo", 1, 0, 0);
        step("tmo", 1, 0, 1);
        repeat (20) step("tmo", 0, 0, 0);
        step("clr", 1, 1, 0);
`endif

        for (int c = 0; c < 800; c++) begin
            if (c == 400) async_reset("rand_rst");
            step("rand", $urandom_range(0, 9) != 0, $urandom_range(0, 40) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fsm_event_counter.md
Name: fsm_event_counter

Overview:
- Parametrised successor to the team's fixed 5-state input-counting FSM.
- Counts qualified events on FSM_in up to a programmable target COUNT_N, then emits a one-cycle completion pulse.
- Adds level/edge event qualification, enable and synchronous clear, auto-restart or hold-after-done, a count readout and an optional inactivity timeout.
- Used as a generic "N occurrences seen" detector in control paths.

Parameters:
- CNT_W, 4, width of the event counter and of FSM_cnt. Must satisfy COUNT_N <= 2^CNT_W.
- COUNT_N, 5, number of events per cycle. Legal range is 2..2^CNT_W.
- EDGE_MODE, 0, event qualification. 0 = each clock FSM_in is high; 1 = each 0->1 transition of FSM_in.
- AUTO_RESTART, 1, behaviour after completion. 1 = return to IDLE; 0 = park in HOLD until FSM_clr.
- TIMEOUT_CYC, 16, number of consecutive event-free cycles in COUNT that abort the sequence. Used only with the optional feature.

Ports:
- Clk  input  1  clock, posedge active
- rst_n  input  1  reset, asynchronous, active-low
- FSM_en  input  1  event qualifier; events are counted only while high
- FSM_clr  input  1  synchronous clear, highest priority
- FSM_in  input  1  event input
- FSM_out  output  1  registered one-cycle completion pulse
- FSM_busy  output  1  high while state is COUNT
- FSM_hold  output  1  high while state is HOLD
- FSM_cnt  output  CNT_W  events accepted in the current sequence
- FSM_timeout  output  1  one-cycle timeout pulse; tied 0 when the optional feature is compiled out

Behaviour:
- Reset (async, rst_n=0): state=IDLE; FSM_cnt=0; FSM_out=0; FSM_timeout=0; in_d=0; timer=0. FSM_busy and FSM_hold are 0.
- Edge detector: in_d <= FSM_in every cycle, independent of FSM_en and state.
- Event definition:
  - EDGE_MODE=0: ev = FSM_en & FSM_in.
  - EDGE_MODE=1: ev = FSM_en & FSM_in & ~in_d.
- State encoding: one-hot plus zero idle. IDLE=3'b000, COUNT=3'b001, HOLD=3'b010. Any other code goes to IDLE on the next edge.
- Structure: two-process FSM (state register plus combinational next-state); outputs are registered.
- Priority per edge: FSM_clr first, then timeout, then ev.
- FSM_clr=1: next state=IDLE; cnt=0; FSM_out=0; timer=0. Any same-cycle event is discarded.
- IDLE:
  - ev -> COUNT, cnt=1.
  - otherwise stay in IDLE, cnt=0.
- COUNT:
  - ev with cnt==COUNT_N-1: cnt=0; FSM_out=1 for the following cycle; next state=IDLE if AUTO_RESTART=1, else HOLD.
  - ev with cnt<COUNT_N-1: cnt=cnt+1.
  - no ev: hold state and cnt.
- HOLD: events are ignored and cnt stays 0. Only FSM_clr leaves HOLD (to IDLE).
- Latency: the final event sampled at edge k makes FSM_out high from edge k to edge k+1. FSM_out is never high for 2 consecutive cycles unless a new full sequence completes. With COUNT_N>=2 that is impossible.
- Back-to-back sequences (AUTO_RESTART=1, EDGE_MODE=0, FSM_in held high): FSM_out pulses every COUNT_N cycles. The cycle after completion is counted as event 1 of the next sequence.
- FSM_en low: no events are counted; state and cnt are held. In EDGE_MODE, an edge occurring while FSM_en=0 is lost.
- Width rule: cnt never exceeds COUNT_N-1 and never wraps.
- Mid-operation reset: immediate return to reset values; no FSM_out is generated.

Optional Feature:
- Macro: FSM_CNT_TIMEOUT_EN.
- Defined:
  - An internal timer of width clog2(TIMEOUT_CYC+1) increments each cycle in COUNT without ev, regardless of FSM_en.
  - The timer clears on ev, on leaving COUNT, and on FSM_clr.
  - When the timer reaches TIMEOUT_CYC: next state=IDLE; cnt=0; FSM_timeout=1 for one cycle; no FSM_out.
  - A same-cycle ev is discarded.
- Undefined: no timer logic is built, FSM_timeout is constant 0, and COUNT waits indefinitely.

Test Plan:
- Defaults; FSM_en=1; FSM_in high for 5 cycles, then low -> FSM_cnt reads 1,2,3,4,0; FSM_out=1 exactly on the cycle after the 5th event; final state IDLE.
- EDGE_MODE=1; FSM_in held high 10 cycles, then 4 more single-cycle pulses -> one event from the long high; FSM_out pulses after the 4th pulse (5 edges total).
- FSM_in gapped: high 2 cycles, FSM_en=0 for 3 cycles, high 3 cycles -> no counting while disabled; FSM_out after the 5th qualified event; FSM_cnt holds 2 during the gap.
- AUTO_RESTART=0; 5 events, then 5 more -> FSM_out pulses once and FSM_hold=1; the next 5 events are ignored; FSM_clr -> IDLE, FSM_hold=0.
- FSM_clr asserted at the same time as the 5th event (FSM_cnt=4) -> no FSM_out; FSM_cnt=0; state IDLE. Also assert rst_n low with FSM_cnt=3 -> all outputs 0 asynchronously.
- FSM_CNT_TIMEOUT_EN defined, TIMEOUT_CYC=16; 2 events, then 16 idle cycles -> FSM_timeout pulses once, FSM_cnt=0, no FSM_out. Repeat with an event at idle cycle 15 -> timer restarts and no timeout occurs.
